// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared state encoding and default widths for the
// count sequencer slice.
//   state_t        : IDLE=0, RUN=1, HOLD=2, DONE=3
//   DEF_WIDTH      : default counter/limit width
//   DEF_PRESCALE_W : default prescale width (prescaler build only)
package count_sequencer_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: control/status bundle between a requester and the
// count sequencer.
//   start, stop, pause, mode, limit : requester -> sequencer
//   prescale                        : requester -> sequencer, only when
//                                     COUNT_SEQUENCER_PRESCALE_EN is defined
//   count, busy, tc, done           : sequencer -> requester
// Modports: master (requester side), slave (sequencer side).
interface count_sequencer_if
    import count_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) ();

    logic                  start;
    logic                  stop;
    logic                  pause;
    logic                  mode;
    logic [WIDTH-1:0]      limit;
`ifdef COUNT_SEQUENCER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tc;
    logic                  done;

    // Reject degenerate widths at elaboration.
    if (WIDTH == 0 || PRESCALE_W == 0) begin : g_param_check
        $error("count_sequencer_if: WIDTH and PRESCALE_W must be non-zero");
    end

    modport master (
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        output prescale,
`endif
        output start, stop, pause, mode, limit,
        input  count, busy, tc, done
    );

    modport slave (
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        input  prescale,
`endif
        input  start, stop, pause, mode, limit,
        output count, busy, tc, done
    );

endinterface

// File: rtl/count_sequencer_core.sv
// count_sequencer_core: WIDTH-bit count register.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force count to zero (start / stop)
//   ld_zero    : reload zero on a periodic terminal count
//   inc        : advance count by one, wrapping modulo 2^WIDTH
//   count      : registered count value
module count_sequencer_core
    import count_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld_zero,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Zeroing sources take priority over increment.
    always_ff @(posedge clk) begin
        if (reset || clr || ld_zero) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: start/stop/pause controlled up-counter with terminal
// count detection, one-shot or periodic operation.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : count_sequencer_if.slave (start, stop, pause, mode, limit,
//           optional prescale in; count, busy, tc, done out)
// Build option: define COUNT_SEQUENCER_PRESCALE_EN to add the prescaler,
// which advances the count once every prescale+1 RUN cycles.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                clk,
    input  logic                reset,
    count_sequencer_if.slave    bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_nxt;
    logic             mode_q;
    logic             mode_nxt;
    logic [WIDTH-1:0] count;
    logic             clr;
    logic             ld_zero;
    logic             inc;
    logic             load;
    logic             tc_int;
    logic             done_int;
    logic             tick;

    // Reject degenerate widths at elaboration.
    if (WIDTH == 0 || PRESCALE_W == 0) begin : g_param_check
        $error("count_sequencer: WIDTH and PRESCALE_W must be non-zero");
    end

    count_sequencer_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .ld_zero (ld_zero),
        .inc     (inc),
        .count   (count)
    );

    // State and run-configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            limit_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            limit_q <= limit_nxt;
            mode_q  <= mode_nxt;
        end
    end

    // Next-state, counter controls and the tc/done pulses.
    always_comb begin
        state_nxt = state;
        limit_nxt = limit_q;
        mode_nxt  = mode_q;
        clr       = 1'b0;
        ld_zero   = 1'b0;
        inc       = 1'b0;
        load      = 1'b0;
        tc_int    = 1'b0;
        done_int  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    clr       = 1'b1;
                    limit_nxt = bus.limit;
                    mode_nxt  = bus.mode;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.pause) begin
                    state_nxt = HOLD;
                end else if (tick) begin
                    if (count == limit_q) begin
                        tc_int = 1'b1;
                        if (mode_q) begin
                            ld_zero = 1'b1;
                        end else begin
                            // One-shot: count stays parked at the limit.
                            state_nxt = DONE;
                        end
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                // The exit cycle itself never advances.
                if (!bus.pause) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                done_int  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Stop overrides everything decided above, including a same-cycle start.
        if (bus.stop) begin
            state_nxt = IDLE;
            clr       = 1'b1;
            ld_zero   = 1'b0;
            inc       = 1'b0;
            load      = 1'b0;
            tc_int    = 1'b0;
            done_int  = 1'b0;
            limit_nxt = limit_q;
            mode_nxt  = mode_q;
        end
    end

`ifdef COUNT_SEQUENCER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == prescale_q);

    // Prescale divider: runs only in un-paused RUN, frozen in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            pre_cnt    <= '0;
        end else begin
            if (load) begin
                prescale_q <= bus.prescale;
            end
            if (load || bus.stop || tc_int) begin
                pre_cnt <= '0;
            end else if (state == RUN && !bus.pause) begin
                pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign bus.count = count;
    assign bus.busy  = (state == RUN) || (state == HOLD);
    assign bus.tc    = tc_int;
    assign bus.done  = done_int;

endmodule
